// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// FSM state encoding and the shift-mode qualifier used by the sequencer.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } usr_state_e;

    // Only shl/shr/rotl/rotr/ashr may be repeated by the auto-shift sequencer.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASHR);
    endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational single-step next-value function for the register contents.
// Used both for en-driven single steps and for each auto-shift step.
module usr_step_logic
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_lsb_i,
    input  logic             sin_msb_i,
    output logic [WIDTH-1:0] q_next_o
);

    // Select the next register value for the requested operation.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        q_next_o = q_i;
        case (mode_i)
            MODE_HOLD: q_next_o = q_i;
            MODE_LOAD: q_next_o = d_i;
            MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], sin_lsb_i};
            MODE_SHR:  q_next_o = {sin_msb_i, q_i[WIDTH-1:1]};
            MODE_ROTL: q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROTR: q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ASHR: q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_CLR:  q_next_o = '0;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register with single-step operations and an
// auto-shift sequencer (IDLE -> RUN -> DONE) that repeats one shift
// mode for a programmable number of cycles with busy/done handshake.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;

    // During RUN the latched mode drives the step logic; otherwise the live mode does.
    assign step_mode = (state_q == ST_RUN) ? mode_q : mode;

    usr_step_logic #(
        .WIDTH(WIDTH)
    ) u_step (
        .q_i       (q_q),
        .mode_i    (step_mode),
        .d_i       (d),
        .sin_lsb_i (sin_lsb),
        .sin_msb_i (sin_msb),
        .q_next_o  (step_q)
    );

    // Next-state, counter, latched-mode and register-value decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (start && is_shift_mode(mode)) begin
                    // A valid start takes precedence over en; q is untouched this edge.
                    if (amount != '0) begin
                        mode_d  = mode;
                        cnt_d   = amount;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (en) begin
                    q_d = step_q;
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched mode and register contents with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make all registers update together from pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
        end
    end

    assign q        = q_q;
    assign qb       = ~q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule
